// File: rtl/cpu_cu_if.sv
// Control-unit bus: instruction/flag/handshake inputs and every execution-unit strobe.
interface cpu_cu_if;
  logic [15:0] ir_out;
  logic        N, Z, C;
  logic        mem_rdy;
  logic        go;
  logic        adr_sel, pc_sel, s_sel;
  logic        pc_ld, pc_inc, reg_w_en, ir_ld;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [3:0]  Alu_Op;
  logic        mem_rd, mem_wr;
  logic        halt;
  logic [2:0]  flags;

  modport master (
    input  ir_out, N, Z, C, mem_rdy, go,
    output adr_sel, pc_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld,
           W_Adr, R_Adr, S_Adr, Alu_Op, mem_rd, mem_wr, halt, flags
  );

  modport slave (
    output ir_out, N, Z, C, mem_rdy, go,
    input  adr_sel, pc_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld,
           W_Adr, R_Adr, S_Adr, Alu_Op, mem_rd, mem_wr, halt, flags
  );
endinterface

// File: rtl/cpu_cu.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer for the CPU execution unit.
// Outputs decode combinationally from the state and the registered instruction.
module cpu_cu #(
  parameter logic [3:0] ALU_PASS_S   = 4'h0,
  parameter logic [3:0] ALU_PASS_DIN = 4'h0
) (
  input logic     clk,
  input logic     rst,
  cpu_cu_if.master bus
);

  // BR and JR are both single-cycle PC updates distinguished by opcode, which
  // keeps the machine within eight states.
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EX_ALU, S_EX_LD, S_EX_ST, S_EX_PC, S_HALT
  } state_t;

  state_t     state;
  logic [2:0] flags_q;

  logic       is_alu;
  logic [2:0] op;
  logic [2:0] cond;
  logic       br_taken;

  assign is_alu   = bus.ir_out[15];
  assign op       = bus.ir_out[14:12];
  assign cond     = bus.ir_out[11:9];
  assign br_taken = (cond == 3'b000) || ((cond & flags_q) != 3'b000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_RESET;
      flags_q <= 3'b000;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (bus.mem_rdy) state <= S_DECODE;
        S_DECODE: begin
          if (is_alu) begin
            state <= S_EX_ALU;
          end else begin
            case (op)
              3'b001:         state <= S_EX_LD;
              3'b010:         state <= S_EX_ST;
              3'b011, 3'b100: state <= S_EX_PC;
              3'b101:         state <= S_HALT;
              default:        state <= S_FETCH;
            endcase
          end
        end
        S_EX_ALU: begin
          flags_q <= {bus.N, bus.Z, bus.C};
          state   <= S_FETCH;
        end
        S_EX_LD:  if (bus.mem_rdy) state <= S_FETCH;
        S_EX_ST:  if (bus.mem_rdy) state <= S_FETCH;
        S_EX_PC:  state <= S_FETCH;
        S_HALT:   if (bus.go) state <= S_FETCH;
        default:  state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    bus.adr_sel  = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.s_sel    = 1'b0;
    bus.pc_ld    = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.reg_w_en = 1'b0;
    bus.ir_ld    = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.halt     = 1'b0;
    bus.W_Adr    = 3'b000;
    bus.R_Adr    = 3'b000;
    bus.S_Adr    = 3'b000;
    bus.Alu_Op   = 4'h0;
    bus.flags    = flags_q;
    if (state != S_RESET) begin
      bus.W_Adr  = bus.ir_out[8:6];
      bus.R_Adr  = bus.ir_out[5:3];
      bus.S_Adr  = bus.ir_out[2:0];
      bus.Alu_Op = is_alu ? bus.ir_out[14:11] : ALU_PASS_S;
    end
    case (state)
      S_FETCH: begin
        bus.mem_rd = 1'b1;
        bus.ir_ld  = bus.mem_rdy;
        bus.pc_inc = bus.mem_rdy;
      end
      S_EX_ALU: bus.reg_w_en = 1'b1;
      S_EX_LD: begin
        bus.mem_rd   = 1'b1;
        bus.adr_sel  = 1'b1;
        bus.s_sel    = 1'b1;
        bus.Alu_Op   = ALU_PASS_DIN;
        bus.reg_w_en = bus.mem_rdy;
      end
      S_EX_ST: begin
        bus.mem_wr  = 1'b1;
        bus.adr_sel = 1'b1;
        bus.Alu_Op  = ALU_PASS_S;
      end
      S_EX_PC: begin
        if (op == 3'b100) begin
          bus.Alu_Op = ALU_PASS_S;
          bus.pc_sel = 1'b1;
          bus.pc_ld  = 1'b1;
        end else begin
          bus.pc_ld  = br_taken;
        end
      end
      S_HALT:  bus.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_cu.sv
// Cycle-by-cycle vector bench for cpu_cu with a scoreboard of expected strobes.
module tb_cpu_cu;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_cu_if bus();

  cpu_cu #(.ALU_PASS_S(4'h0), .ALU_PASS_DIN(4'h0)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // Strobe word: {adr_sel,pc_sel,s_sel,pc_ld,pc_inc,reg_w_en,ir_ld,mem_rd,mem_wr,halt}
  localparam logic [9:0] B_ADR  = 10'h200, B_PCS = 10'h100, B_SS  = 10'h080;
  localparam logic [9:0] B_PLD  = 10'h040, B_PINC = 10'h020, B_RW = 10'h010;
  localparam logic [9:0] B_IRL  = 10'h008, B_MRD = 10'h004, B_MWR = 10'h002;
  localparam logic [9:0] B_HLT  = 10'h001;
  localparam logic [9:0] FRDY   = B_MRD | B_IRL | B_PINC;
  localparam logic [9:0] LDW    = B_MRD | B_ADR | B_SS;
  localparam logic [9:0] STW    = B_MWR | B_ADR;

  // Field word: {W_Adr,R_Adr,S_Adr,Alu_Op}
  localparam logic [12:0] F_ALU = {3'd1, 3'd2, 3'd3, 4'h1};
  localparam logic [12:0] F_LD  = {3'd1, 3'd2, 3'd0, 4'h0};
  localparam logic [12:0] F_ST  = {3'd0, 3'd2, 3'd3, 4'h0};
  localparam logic [12:0] F_JR  = {3'd0, 3'd0, 3'd5, 4'h0};

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzc;
    logic        rdy;
    logic        go;
    logic [9:0]  strb;
    logic [2:0]  flg;
    logic        chk;
    logic [12:0] fld;
  } vec_t;

  typedef struct {
    logic [9:0]  strb;
    logic [2:0]  flg;
    logic        chk;
    logic [12:0] fld;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   split_a, split_b;

  function automatic logic [9:0] strobes();
    return {bus.adr_sel, bus.pc_sel, bus.s_sel, bus.pc_ld, bus.pc_inc,
            bus.reg_w_en, bus.ir_ld, bus.mem_rd, bus.mem_wr, bus.halt};
  endfunction

  function automatic logic [12:0] fields();
    return {bus.W_Adr, bus.R_Adr, bus.S_Adr, bus.Alu_Op};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] ir, input logic [2:0] nzc, input logic rdy,
                     input logic go, input logic [9:0] s, input logic [2:0] f,
                     input logic chk = 1'b0, input logic [12:0] fld = 13'h0);
    vec_t v;
    v.ir = ir; v.nzc = nzc; v.rdy = rdy; v.go = go;
    v.strb = s; v.flg = f; v.chk = chk; v.fld = fld;
    tbl.push_back(v);
  endtask

  task automatic add_fd(input logic [15:0] ir, input logic [2:0] f);
    add(ir, 3'b000, 1'b1, 1'b0, FRDY, f);
    add(ir, 3'b000, 1'b1, 1'b0, 10'h000, f);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk); #1;
    bus.ir_out = v.ir;
    {bus.N, bus.Z, bus.C} = v.nzc;
    bus.mem_rdy = v.rdy;
    bus.go = v.go;
    e.strb = v.strb; e.flg = v.flg; e.chk = v.chk; e.fld = v.fld; e.idx = idx;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check($sformatf("vec%0d strobes", e.idx), {6'h0, strobes()}, {6'h0, e.strb});
    check($sformatf("vec%0d flags", e.idx), {13'h0, bus.flags}, {13'h0, e.flg});
    if (e.chk) check($sformatf("vec%0d fields", e.idx), {3'h0, fields()}, {3'h0, e.fld});
    check($sformatf("vec%0d pc_ld&pc_inc", e.idx), {15'h0, bus.pc_ld & bus.pc_inc}, 16'h0);
    check($sformatf("vec%0d mem_rd&mem_wr", e.idx), {15'h0, bus.mem_rd & bus.mem_wr}, 16'h0);
  endtask

  initial begin
    bus.ir_out = 16'h0; bus.N = 1'b0; bus.Z = 1'b0; bus.C = 1'b0;
    bus.mem_rdy = 1'b1; bus.go = 1'b0;

    // NOP, then ALU latching N=1 C=1; go pulses outside HALT are ignored
    add_fd(16'h0000, 3'b000);
    add(16'h8A53, 3'b000, 1'b1, 1'b0, FRDY, 3'b000);
    add(16'h8A53, 3'b000, 1'b1, 1'b0, 10'h000, 3'b000, 1'b1, F_ALU);
    add(16'h8A53, 3'b101, 1'b1, 1'b1, B_RW, 3'b000, 1'b1, F_ALU);
    // LD with a fetch wait and two memory wait cycles
    add(16'h1050, 3'b000, 1'b0, 1'b1, B_MRD, 3'b101);
    add_fd(16'h1050, 3'b101);
    add(16'h1050, 3'b000, 1'b0, 1'b0, LDW, 3'b101, 1'b1, F_LD);
    add(16'h1050, 3'b000, 1'b0, 1'b0, LDW, 3'b101, 1'b1, F_LD);
    add(16'h1050, 3'b000, 1'b1, 1'b0, LDW | B_RW, 3'b101, 1'b1, F_LD);
    // ST with one wait
    add_fd(16'h2013, 3'b101);
    add(16'h2013, 3'b000, 1'b0, 1'b0, STW, 3'b101, 1'b1, F_ST);
    add(16'h2013, 3'b000, 1'b1, 1'b0, STW, 3'b101, 1'b1, F_ST);
    // Z set, BR on Z taken
    add_fd(16'h8A53, 3'b101);
    add(16'h8A53, 3'b010, 1'b1, 1'b0, B_RW, 3'b101);
    add_fd(16'h3404, 3'b010);
    add(16'h3404, 3'b111, 1'b1, 1'b0, B_PLD, 3'b010);
    // flags cleared, BR on Z not taken, unconditional BR taken
    add_fd(16'h8A53, 3'b010);
    add(16'h8A53, 3'b000, 1'b1, 1'b0, B_RW, 3'b010);
    add_fd(16'h3404, 3'b000);
    add(16'h3404, 3'b111, 1'b1, 1'b0, 10'h000, 3'b000);
    add_fd(16'h3004, 3'b000);
    add(16'h3004, 3'b000, 1'b1, 1'b0, B_PLD, 3'b000);
    // JR, then both illegal opcodes behave as NOP
    add_fd(16'h4005, 3'b000);
    add(16'h4005, 3'b000, 1'b1, 1'b0, B_PLD | B_PCS, 3'b000, 1'b1, F_JR);
    add_fd(16'h6000, 3'b000);
    add_fd(16'h7000, 3'b000);
    // HALT held ten cycles, then released by go
    add_fd(16'h5000, 3'b000);
    for (int i = 0; i < 10; i++) add(16'h5000, 3'b000, 1'b1, 1'b0, B_HLT, 3'b000);
    add(16'h5000, 3'b000, 1'b1, 1'b1, B_HLT, 3'b000);
    add_fd(16'h0000, 3'b000);
    // flags=111 then stall in ST, where reset will hit
    add_fd(16'h8A53, 3'b000);
    add(16'h8A53, 3'b111, 1'b1, 1'b0, B_RW, 3'b000);
    add_fd(16'h2013, 3'b111);
    add(16'h2013, 3'b000, 1'b0, 1'b0, STW, 3'b111, 1'b1, F_ST);
    split_a = tbl.size();
    add_fd(16'h0000, 3'b000);
    add(16'h0000, 3'b000, 1'b1, 1'b0, FRDY, 3'b000);
    split_b = tbl.size();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset strobes", {6'h0, strobes()}, 16'h0);
    check("reset flags", {13'h0, bus.flags}, 16'h0);
    check("reset fields", {3'h0, fields()}, 16'h0);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("RESET cycle strobes", {6'h0, strobes()}, 16'h0);

    for (int i = 0; i < split_a; i++) run_vec(tbl[i], i);

    // Mid-access reset must drop mem_wr without a clock edge
    #1 rst_n = 1'b0;
    #1;
    check("async reset mem_wr", {15'h0, bus.mem_wr}, 16'h0);
    check("async reset strobes", {6'h0, strobes()}, 16'h0);
    check("async reset flags", {13'h0, bus.flags}, 16'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    check("post-reset RESET strobes", {6'h0, strobes()}, 16'h0);

    for (int i = split_a; i < split_b; i++) run_vec(tbl[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end
endmodule

// File: doc/cpu_cu.md
Name: cpu_cu

Overview:
Multi-cycle control unit that sequences the CPU execution unit: register file/ALU datapath, PC, IR, and the address/PC muxes.
- Walks FETCH/DECODE/EXECUTE from the registered instruction word.
- Drives every execution-unit control strobe and the memory read/write strobes.
- Stalls on a memory ready handshake.
- Holds a latched N/Z/C flag register for conditional branches.

Parameters:
ALU_PASS_S, 4'h0, Alu_Op code that passes the S operand to D_out
ALU_PASS_DIN, 4'h0, Alu_Op code used with s_sel=1 to route D_in to the register write port

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
ir_out  in  16  instruction register contents
N  in  1  ALU negative flag, combinational
Z  in  1  ALU zero flag, combinational
C  in  1  ALU carry flag, combinational
mem_rdy  in  1  memory access complete this cycle
go  in  1  restart pulse from HALT
adr_sel  out  1  1 = address from register R, 0 = PC
pc_sel  out  1  1 = PC load from D_out, 0 = sign-extended offset + PC
s_sel  out  1  1 = D_in to datapath S input
pc_ld  out  1  PC load
pc_inc  out  1  PC increment
reg_w_en  out  1  register file write
ir_ld  out  1  IR load
W_Adr  out  3  write register
R_Adr  out  3  R register
S_Adr  out  3  S register
Alu_Op  out  4  ALU operation
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
halt  out  1  1 while in HALT
flags  out  3  latched {N,Z,C}

Behaviour:
Encoding:
- ir[15]=1, ALU: Alu_Op=ir[14:11], W=ir[8:6], R=ir[5:3], S=ir[2:0].
- ir[15]=0: op=ir[14:12].
  - 000 NOP
  - 001 LD reg[ir[8:6]] <= mem[reg[ir[5:3]]]
  - 010 ST mem[reg[ir[5:3]]] <= reg[ir[2:0]]
  - 011 BR: cond=ir[11:9], off=ir[7:0]
  - 100 JR: PC <= reg[ir[2:0]]
  - 101 HALT
  - 110 and 111 are illegal and execute as NOP.

Structure:
- State register and flag register are sequential.
- All outputs are combinational from the state and ir_out.
- Any strobe not listed for a state is 0.
- W/R/S/Alu_Op outputs are always the decoded field values.

States (3-bit register):
- RESET: next state FETCH.
- FETCH: mem_rd=1, adr_sel=0, ir_ld=mem_rdy, pc_inc=mem_rdy.
  - Stay in FETCH while mem_rdy=0 (no IR or PC change).
  - Go to DECODE when mem_rdy=1.
- DECODE: no strobes. Dispatch to the execute state by opcode. NOP/illegal go to FETCH.
- EX_ALU: reg_w_en=1, s_sel=0. Flags latch {N,Z,C} at the clock edge. Next state FETCH.
- EX_LD: mem_rd=1, adr_sel=1, s_sel=1, Alu_Op=ALU_PASS_DIN, reg_w_en=mem_rdy. Hold until mem_rdy=1, then FETCH. Flags unchanged.
- EX_ST: mem_wr=1, adr_sel=1, Alu_Op=ALU_PASS_S, reg_w_en=0. Hold until mem_rdy=1, then FETCH.
- EX_BR:
  - Taken when cond==000, or when (cond & flags)!=0.
  - If taken: pc_sel=0, pc_ld=1. Target = incremented PC + sext(off).
  - Next state FETCH.
- EX_JR: S_Adr=ir[2:0], Alu_Op=ALU_PASS_S, pc_sel=1, pc_ld=1. Next state FETCH.
- HALT: halt=1, all strobes 0. Stay in HALT until go=1 at a clock edge, then FETCH. go is ignored in every other state.

Latency:
- NOP = 2 cycles; ALU/BR/JR = 3 cycles; LD/ST = 3 cycles plus memory wait cycles.
- FETCH waits add to every instruction.

Rules:
- pc_ld and pc_inc are never asserted together.
- mem_rd and mem_wr are never asserted together.

Reset:
- Asserting rst (low) forces state=RESET and flags=000 immediately, including mid-access.
- While in RESET all outputs are 0 and halt=0.
- After release, the first FETCH occurs one cycle later.

Test Plan:
- Reset release with mem_rdy=1 and ir=NOP -> RESET, FETCH (ir_ld=1, pc_inc=1, mem_rd=1), DECODE, FETCH; no reg_w_en; flags=000.
- ir=16'h8A53 (Alu_Op=4'h1, W=1, R=2, S=3), N=1 Z=0 C=1 during EX_ALU -> reg_w_en=1 for exactly one cycle with W_Adr=1, R_Adr=2, S_Adr=3; flags=3'b101 afterwards.
- LD ir=16'h1050 with mem_rdy low for 2 cycles in EX_LD -> adr_sel=1, s_sel=1, mem_rd=1 held 3 cycles; reg_w_en=1 only in the mem_rdy cycle; W_Adr=1, R_Adr=2.
- BR ir=16'h3404 (cond=010): with flags Z=1 -> pc_ld=1, pc_sel=0 in EX_BR; with flags=000 -> pc_ld=0; cond=000 -> pc_ld=1 regardless of flags.
- HALT ir=16'h5000 -> halt=1 and all strobes 0 for 10 cycles with go=0; go=1 -> next state FETCH, halt=0.
- Assert rst low during EX_ST with mem_wr=1 -> mem_wr drops immediately without waiting for a clock, state=RESET; after release, restart at FETCH.
